// File: rtl/vm_agent_qdma_cfg_arbiter.sv
// Two-requester round-robin front end to a single AXI4-Lite config master, one transaction in flight.
// Optional response watchdog enabled by defining VM_AGENT_CFG_ARB_TIMEOUT_EN.
module vm_agent_qdma_cfg_arbiter #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW_W,
    S_B,
    S_AR,
    S_R,
    S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic                take;
  logic                win;
  logic                tmo_hit;
  logic                tmo_fire;
  logic                last_grant_q;
  logic                aw_pend_q, w_pend_q, ar_pend_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          resp_q;

  // next state, grant and one-cycle pulses
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    win       = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    tmo_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ARESETN && (req_valid != 2'b00)) begin
          take           = 1'b1;
          win            = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
          req_ready[win] = 1'b1;
          state_d        = req_write[win] ? S_AW_W : S_AR;
        end
      end
      S_AW_W: begin
        // AW and W retire independently; both may land in the same cycle
        if ((!aw_pend_q || m_axi_awready) && (!w_pend_q || m_axi_wready))
          state_d = S_B;
      end
      S_B: begin
        if (m_axi_bvalid) state_d = S_RSP;
      end
      S_AR: begin
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        if (m_axi_rvalid) state_d = S_RSP;
      end
      S_RSP: begin
        rsp_valid[last_grant_q] = 1'b1;
        state_d                 = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit && (state_d == state_q)) begin
      tmo_fire = 1'b1;
      state_d  = S_RSP;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // command capture, channel valids and response capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant_q <= 1'b1;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      ar_pend_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      if (take) begin
        last_grant_q <= win;
        addr_q       <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        wdata_q      <= win ? req_wdata[63:32] : req_wdata[31:0];
        aw_pend_q    <= req_write[win];
        w_pend_q     <= req_write[win];
        ar_pend_q    <= ~req_write[win];
      end
      if (aw_pend_q && m_axi_awready) aw_pend_q <= 1'b0;
      if (w_pend_q && m_axi_wready)   w_pend_q  <= 1'b0;
      if (ar_pend_q && m_axi_arready) ar_pend_q <= 1'b0;
      if ((state_q == S_B) && m_axi_bvalid) begin
        resp_q  <= m_axi_bresp;
        rdata_q <= '0;
      end
      if ((state_q == S_R) && m_axi_rvalid) begin
        resp_q  <= m_axi_rresp;
        rdata_q <= m_axi_rdata;
      end
      if (tmo_fire) begin
        aw_pend_q <= 1'b0;
        w_pend_q  <= 1'b0;
        ar_pend_q <= 1'b0;
        resp_q    <= 2'b10;
        rdata_q   <= '0;
      end
    end
  end

`ifdef VM_AGENT_CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic             waiting;
  logic [CNT_W-1:0] tmo_cnt_q;

  assign waiting = (state_q == S_AW_W) || (state_q == S_B) ||
                   (state_q == S_AR)   || (state_q == S_R);

  // counts cycles spent in the current wait state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                               tmo_cnt_q <= '0;
    else if (!waiting || (state_d != state_q))  tmo_cnt_q <= '0;
    else                                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = waiting && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // watchdog compiled out: never fires
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = aw_pend_q;
  assign m_axi_wvalid  = w_pend_q;
  assign m_axi_arvalid = ar_pend_q;
  assign m_axi_bready  = (state_q == S_B);
  assign m_axi_rready  = (state_q == S_R);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_vm_agent_qdma_cfg_arbiter.sv
// Directed bench for vm_agent_qdma_cfg_arbiter with a small programmable AXI4-Lite slave.
module tb_vm_agent_qdma_cfg_arbiter;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 256;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic [1:0]          req_valid, req_write, req_ready, rsp_valid, rsp_resp;
  logic [2*ADDR_W-1:0] req_addr;
  logic [63:0]         req_wdata;
  logic [31:0]         rsp_rdata;
  logic [ADDR_W-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]          m_axi_awprot, m_axi_arprot;
  logic                m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]         m_axi_wdata, m_axi_rdata;
  logic [3:0]          m_axi_wstrb;
  logic [1:0]          m_axi_bresp, m_axi_rresp;
  logic                m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic                m_axi_rvalid, m_axi_rready;

  always #5 ACLK = ~ACLK;

  vm_agent_qdma_cfg_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // slave model: ready after a programmable number of waiting cycles
  int          aw_wait, w_wait, aw_cnt, w_cnt;
  int          aw_hs_n = 0, w_hs_n = 0;
  bit          b_en;
  logic        aw_done, w_done, sl_aw_d, sl_w_d;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_bresp   = 2'b00;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt       <= 0;
      w_cnt        <= 0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= '0;
      m_axi_rresp  <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) aw_hs_n <= aw_hs_n + 1;
      if (m_axi_wvalid && m_axi_wready)   w_hs_n  <= w_hs_n + 1;
      sl_aw_d = aw_done | (m_axi_awvalid & m_axi_awready);
      sl_w_d  = w_done | (m_axi_wvalid & m_axi_wready);
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (sl_aw_d && sl_w_d) begin
        m_axi_bvalid <= b_en;
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
      end else begin
        aw_done <= sl_aw_d;
        w_done  <= sl_w_d;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= rd_val;
        m_axi_rresp  <= rd_resp;
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // lat = index of the first negedge showing rsp_valid, counted from base; -1 if none by limit
  task automatic wait_rsp(input int base, input int limit, output int lat, output logic [1:0] v);
    int i;
    i = base;
    while ((rsp_valid == 2'b00) && (i < limit)) begin
      @(negedge ACLK); #1;
      i++;
    end
    v   = rsp_valid;
    lat = (rsp_valid == 2'b00) ? -1 : i;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    int i;
    i = 0;
    #1;
    while ((req_ready == 2'b00) && (i < 10)) begin
      @(negedge ACLK); #1;
      i++;
    end
    g = req_ready;
  endtask

  initial begin
    int         lat, base_aw, base_w;
    logic [1:0] v, g, exp_g;

    ARESETN   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    aw_wait   = 0;
    w_wait    = 0;
    b_en      = 1'b1;
    rd_val    = '0;
    rd_resp   = 2'b00;

    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_bready", m_axi_bready, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_awaddr", m_axi_awaddr, 4'h0);

    @(negedge ACLK);
    req_valid = 2'b00;
    ARESETN   = 1'b1;
    @(negedge ACLK);

    // req0 write 0x2 to 0x4, zero-wait slave
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h04; req_wdata = 64'h0000_0000_0000_0002;
    base_aw = aw_hs_n; base_w = w_hs_n;
    #1 chk("wr0_req_ready", req_ready, 2'b01);
    @(negedge ACLK);
    req_valid = 2'b00;
    #1;
    chk("wr0_awvalid", m_axi_awvalid, 1'b1);
    chk("wr0_wvalid", m_axi_wvalid, 1'b1);
    chk("wr0_awaddr", m_axi_awaddr, 4'h4);
    chk("wr0_wdata", m_axi_wdata, 32'h2);
    chk("wr0_wstrb", m_axi_wstrb, 4'hF);
    chk("wr0_awprot", m_axi_awprot, 3'b000);
    wait_rsp(1, 20, lat, v);
    chk("wr0_latency", lat, 3);
    chk("wr0_rsp_valid", v, 2'b01);
    chk("wr0_rsp_resp", rsp_resp, 2'b00);
    chk("wr0_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr0_aw_hs", aw_hs_n - base_aw, 1);
    chk("wr0_w_hs", w_hs_n - base_w, 1);
    @(negedge ACLK); #1;
    chk("wr0_rsp_one_cycle", rsp_valid, 2'b00);

    // req1 read from 0x8, slave returns 0x3
    req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h80; rd_val = 32'h3; rd_resp = 2'b00;
    #1 chk("rd1_req_ready", req_ready, 2'b10);
    @(negedge ACLK);
    req_valid = 2'b00;
    #1;
    chk("rd1_arvalid", m_axi_arvalid, 1'b1);
    chk("rd1_araddr", m_axi_araddr, 4'h8);
    chk("rd1_arprot", m_axi_arprot, 3'b000);
    chk("rd1_no_awvalid", m_axi_awvalid, 1'b0);
    wait_rsp(1, 20, lat, v);
    chk("rd1_latency", lat, 3);
    chk("rd1_rsp_valid", v, 2'b10);
    chk("rd1_rsp_rdata", rsp_rdata, 32'h3);
    chk("rd1_rsp_resp", rsp_resp, 2'b00);
    @(negedge ACLK); #1;
    chk("rd1_rsp_one_cycle", rsp_valid, 2'b00);

    // write with W accepted in cycle 1 and AW in cycle 4
    aw_wait = 3; w_wait = 0;
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h00; req_wdata = 64'h5;
    base_aw = aw_hs_n; base_w = w_hs_n;
    #1 chk("skew_req_ready", req_ready, 2'b01);
    @(negedge ACLK);
    req_valid = 2'b00;
    #1;
    chk("skew_c1_wvalid", m_axi_wvalid, 1'b1);
    chk("skew_c1_awvalid", m_axi_awvalid, 1'b1);
    @(negedge ACLK); #1;
    chk("skew_c2_wvalid", m_axi_wvalid, 1'b0);
    chk("skew_c2_awvalid", m_axi_awvalid, 1'b1);
    @(negedge ACLK); #1;
    @(negedge ACLK); #1;
    chk("skew_c4_awvalid", m_axi_awvalid, 1'b1);
    chk("skew_c4_awready", m_axi_awready, 1'b1);
    @(negedge ACLK); #1;
    chk("skew_c5_awvalid", m_axi_awvalid, 1'b0);
    chk("skew_c5_bready", m_axi_bready, 1'b1);
    wait_rsp(5, 30, lat, v);
    chk("skew_latency", lat, 6);
    chk("skew_rsp_valid", v, 2'b01);
    chk("skew_aw_hs", aw_hs_n - base_aw, 1);
    chk("skew_w_hs", w_hs_n - base_w, 1);
    aw_wait = 0;
    @(negedge ACLK);

    // bvalid withheld
    b_en = 1'b0;
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h0C; req_wdata = 64'h7;
    #1 chk("hang_req_ready", req_ready, 2'b01);
    @(negedge ACLK);
    req_valid = 2'b00;
    #1;
`ifdef VM_AGENT_CFG_ARB_TIMEOUT_EN
    wait_rsp(1, 400, lat, v);
    chk("tmo_latency", lat, 258);
    chk("tmo_rsp_valid", v, 2'b01);
    chk("tmo_rsp_resp", rsp_resp, 2'b10);
    chk("tmo_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge ACLK); #1;
    chk("tmo_idle_bready", m_axi_bready, 1'b0);
    chk("tmo_idle_rsp", rsp_valid, 2'b00);
    req_valid = 2'b01;
    #1 chk("tmo_regrant", req_ready, 2'b01);
    @(negedge ACLK);
    req_valid = 2'b00;
    @(negedge ACLK); #1;
`else
    wait_rsp(1, 300, lat, v);
    chk("hang_no_rsp", lat, -1);
    chk("hang_stuck_b", m_axi_bready, 1'b1);
`endif

    // async reset while waiting in B
    chk("arst_in_b", m_axi_bready, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_bready", m_axi_bready, 1'b0);
    chk("arst_awvalid", m_axi_awvalid, 1'b0);
    chk("arst_wvalid", m_axi_wvalid, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 2'b00);
    chk("arst_req_ready", req_ready, 2'b00);
    chk("arst_awaddr", m_axi_awaddr, 4'h0);
    chk("arst_wdata", m_axi_wdata, 32'h0);
    chk("arst_rsp_resp", rsp_resp, 2'b00);
    @(negedge ACLK);
    ARESETN = 1'b1;
    b_en    = 1'b1;

    // both requesters valid continuously: strict alternation starting with req0
    req_valid = 2'b11; req_write = 2'b11; req_addr = 8'hC4;
    req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(g);
      chk($sformatf("rr_grant%0d", k), g, exp_g);
      @(negedge ACLK); #1;
      chk($sformatf("rr_awaddr%0d", k), m_axi_awaddr, (exp_g == 2'b01) ? 4'h4 : 4'hC);
      chk($sformatf("rr_wdata%0d", k), m_axi_wdata,
          (exp_g == 2'b01) ? 32'hAAAA_0000 : 32'hBBBB_0001);
    end
    req_valid = 2'b00;
    repeat (8) @(negedge ACLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vm_agent_qdma_cfg_arbiter.md
VM_AGENT_QDMA_CFG_ARBITER -- requirements
Module: vm_agent_qdma_cfg_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the byte-address width of the demux register space (4 x 32-bit registers).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, meaning the response watchdog limit in cycles (used only under REQ-024).
REQ-003 SHALL have port ACLK  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  2  per-requester command valid.
REQ-006 SHALL have port req_write  in  2  per-requester 1=write, 0=read.
REQ-007 SHALL have port req_addr  in  2*ADDR_W  per-requester byte address; requester n is in slice n.
REQ-008 SHALL have port req_wdata  in  64  per-requester write data; requester n uses bits [32n+31:32n].
REQ-009 SHALL have port req_ready  out  2  one-cycle command-accept pulse.
REQ-010 SHALL have port rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rsp_rdata  out  32  read data, qualified by rsp_valid.
REQ-012 SHALL have port rsp_resp  out  2  AXI response code, qualified by rsp_valid.
REQ-013 SHALL have AXI4-Lite master ports m_axi_awaddr (out, ADDR_W), awprot (out, 3), awvalid (out), awready (in), wdata (out, 32), wstrb (out, 4), wvalid (out), wready (in), bresp (in, 2), bvalid (in), bready (out), araddr (out, ADDR_W), arprot (out, 3), arvalid (out), arready (in), rdata (in, 32), rresp (in, 2), rvalid (in), rready (out).

Function
REQ-014 SHALL run the FSM IDLE -> (AW_W -> B | AR -> R) -> RSP -> IDLE, with exactly one AXI transaction outstanding.
REQ-015 In IDLE with any req_valid set, SHALL grant one requester, pulse its req_ready for that cycle, capture its write/addr/wdata, and go to AW_W (write) or AR (read).
REQ-016 Arbitration SHALL be round-robin: a last_grant register holds the last winner; when both requesters are valid, the requester other than last_grant wins; a sole requester always wins.
REQ-017 In AW_W, awvalid and wvalid SHALL both assert; each SHALL deassert independently after its own handshake; the FSM SHALL enter B once both handshakes are done, including when both occur in the same cycle.
REQ-018 In B, bready=1; on bvalid, bresp SHALL be captured and the FSM SHALL go to RSP.
REQ-019 In AR, arvalid=1 until arready; in R, rready=1; on rvalid, rdata and rresp SHALL be captured and the FSM SHALL go to RSP.
REQ-020 RSP SHALL last exactly one cycle: rsp_valid[grant]=1 with the captured rdata and resp; rsp_rdata=0 for writes; rsp_valid has no backpressure.
REQ-021 wstrb SHALL be 4'hF and awprot/arprot SHALL be 3'b000; AXI address and data outputs SHALL hold stable while their valid is high.
REQ-022 With a zero-wait slave, rsp_valid SHALL assert exactly 3 cycles after req_ready, giving a 4-cycle turnaround back to IDLE.

Reset
REQ-023 ARESETN low SHALL immediately force the state to IDLE, all valid/ready/rsp outputs to 0, data outputs to 0, and last_grant to 1 (requester 0 wins first); any in-flight transaction is abandoned without a response.

Configuration
REQ-024 Macro VM_AGENT_CFG_ARB_TIMEOUT_EN: when defined, a counter SHALL run in AW_W, B, AR and R; after TIMEOUT_CYC cycles without completion the FSM SHALL drop all AXI valids, go to RSP with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0. When undefined, the FSM SHALL wait indefinitely and no counter SHALL be built.

Verification
REQ-025 Req0 writes addr 0x4, data 0x00000002, zero-wait slave -> awaddr=0x4, wdata=0x2, wstrb=0xF; rsp_valid[0] 3 cycles after req_ready[0]; rsp_resp=0.
REQ-026 Both requesters valid continuously from reset -> grant order 0,1,0,1; no requester receives two consecutive grants.
REQ-027 Write with wready at cycle 1 and awready at cycle 4 -> wvalid drops after cycle 1, awvalid held until cycle 4, exactly one AW and one W handshake.
REQ-028 Req1 reads addr 0x8, slave returns rdata 0x00000003, rresp=0 -> rsp_valid[1] for one cycle with rsp_rdata=0x3; rsp_valid[0] stays 0.
REQ-029 bvalid never asserted -> with macro: rsp_resp=2'b10 after 256 cycles in B, then return to IDLE; without macro: FSM remains in B.
REQ-030 ARESETN pulled low while in B -> all outputs 0 asynchronously; after release, req0 is granted first.
